// File: rtl/cs_address_sequencer_pkg.sv
// Encodings shared by the control-store sequencer and the branch logic that drives it.
// Constants only: no logic, latency or flow control of its own.
package cs_address_sequencer_pkg;

    localparam logic [1:0] TIPO_NEXT   = 2'b00;
    localparam logic [1:0] TIPO_JUMP   = 2'b01;
    localparam logic [1:0] TIPO_DECODE = 2'b10;
    localparam logic [1:0] TIPO_RSVD   = 2'b11;

    localparam logic [1:0] ST_PRIME = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic DECODE_PREFIX = 1'b1;

endpackage

// File: rtl/cs_address_sequencer_next_addr_mux.sv
// Four-way next control-store address select (next / jump / decode / reserved-as-next).
// Purely combinational, zero latency; stalls are applied by the caller, not here.
module cs_address_sequencer_next_addr_mux
    import cs_address_sequencer_pkg::*;
#(
    parameter int ADDR = 11,
    parameter int TIPO = 2,
    parameter int OP   = 2,
    parameter int OP3  = 6
) (
    input  logic [TIPO-1:0] tipo,
    input  logic [ADDR-1:0] jump_addr,
    input  logic [ADDR-1:0] upc,
    input  logic [OP-1:0]   ir_op,
    input  logic [OP3-1:0]  ir_op3,
    output logic [ADDR-1:0] next_addr,
    output logic            decode,
    output logic            illegal
);

    always_comb begin
        next_addr = upc + ADDR'(1);
        decode    = 1'b0;
        illegal   = 1'b0;
        case (tipo)
            TIPO_JUMP: next_addr = jump_addr;
            TIPO_DECODE: begin
                // Each opcode owns a 4-word slot in the upper half of the store.
                next_addr = {DECODE_PREFIX, ir_op, ir_op3, 2'b00};
                decode    = 1'b1;
            end
            TIPO_RSVD: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cs_address_sequencer.sv
// Micro-PC sequencer: combinational ROM address, registered uPC one cycle later.
// Wait_In freezes the uPC and re-presents it so the ROM re-reads the same word.
module cs_address_sequencer
    import cs_address_sequencer_pkg::*;
#(
    parameter int CS_ADDRESS_SEQUENCER_ADDR = 11,
    parameter int CS_ADDRESS_SEQUENCER_TIPO = 2,
    parameter int CS_ADDRESS_SEQUENCER_OP   = 2,
    parameter int CS_ADDRESS_SEQUENCER_OP3  = 6
) (
    input  logic                                  CS_ADDRESS_SEQUENCER_CLOCK_50,
    input  logic                                  CS_ADDRESS_SEQUENCER_ResetInHigh_In,
    input  logic [CS_ADDRESS_SEQUENCER_TIPO-1:0]  CS_ADDRESS_SEQUENCER_Tipo_InBus,
    input  logic [CS_ADDRESS_SEQUENCER_ADDR-1:0]  CS_ADDRESS_SEQUENCER_JumpAddr_InBus,
    input  logic [CS_ADDRESS_SEQUENCER_OP-1:0]    CS_ADDRESS_SEQUENCER_IrOp_InBus,
    input  logic [CS_ADDRESS_SEQUENCER_OP3-1:0]   CS_ADDRESS_SEQUENCER_IrOp3_InBus,
    input  logic                                  CS_ADDRESS_SEQUENCER_Wait_In,
    output logic [CS_ADDRESS_SEQUENCER_ADDR-1:0]  CS_ADDRESS_SEQUENCER_CsAddr_OutBus,
    output logic [CS_ADDRESS_SEQUENCER_ADDR-1:0]  CS_ADDRESS_SEQUENCER_MicroPc_OutBus,
    output logic                                  CS_ADDRESS_SEQUENCER_Decode_Out,
    output logic                                  CS_ADDRESS_SEQUENCER_IllegalTipo_Out
);

    localparam int ADDR = CS_ADDRESS_SEQUENCER_ADDR;

    if (1 + CS_ADDRESS_SEQUENCER_OP + CS_ADDRESS_SEQUENCER_OP3 + 2 != ADDR) begin : g_bad_decode_width
        $error("decode address {1, op, op3, 00} does not fill the control-store address width");
    end

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic [ADDR-1:0] upc;
    logic [ADDR-1:0] mux_addr;
    logic            mux_decode;
    logic            mux_illegal;
    logic [ADDR-1:0] cs_addr;
    logic            decode;
    logic            illegal;

    cs_address_sequencer_next_addr_mux #(
        .ADDR (ADDR),
        .TIPO (CS_ADDRESS_SEQUENCER_TIPO),
        .OP   (CS_ADDRESS_SEQUENCER_OP),
        .OP3  (CS_ADDRESS_SEQUENCER_OP3)
    ) u_next_addr_mux (
        .tipo      (CS_ADDRESS_SEQUENCER_Tipo_InBus),
        .jump_addr (CS_ADDRESS_SEQUENCER_JumpAddr_InBus),
        .upc       (upc),
        .ir_op     (CS_ADDRESS_SEQUENCER_IrOp_InBus),
        .ir_op3    (CS_ADDRESS_SEQUENCER_IrOp3_InBus),
        .next_addr (mux_addr),
        .decode    (mux_decode),
        .illegal   (mux_illegal)
    );

    // PRIME forces address 0 because the ROM has not yet produced a valid MIR word.
    always_comb begin
        cs_addr    = '0;
        decode     = 1'b0;
        illegal    = 1'b0;
        next_state = ST_PRIME;
        if (!CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
            case (state)
                ST_PRIME: next_state = ST_RUN;
                ST_RUN, ST_HOLD: begin
                    if (CS_ADDRESS_SEQUENCER_Wait_In) begin
                        cs_addr    = upc;
                        next_state = ST_HOLD;
                    end else begin
                        cs_addr    = mux_addr;
                        decode     = mux_decode;
                        illegal    = mux_illegal;
                        next_state = ST_RUN;
                    end
                end
                default: next_state = ST_PRIME;
            endcase
        end
    end

    always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50) begin
        if (CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
            state <= ST_PRIME;
            upc   <= '0;
        end else begin
            state <= next_state;
            upc   <= cs_addr;
        end
    end

    assign CS_ADDRESS_SEQUENCER_CsAddr_OutBus    = cs_addr;
    assign CS_ADDRESS_SEQUENCER_MicroPc_OutBus   = upc;
    assign CS_ADDRESS_SEQUENCER_Decode_Out       = decode;
    assign CS_ADDRESS_SEQUENCER_IllegalTipo_Out  = illegal;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed and random bench for cs_address_sequencer against a cycle-level reference model.
module tb_cs_address_sequencer;

    logic        clk;
    logic        rst;
    logic [1:0]  tipo;
    logic [10:0] jump;
    logic [1:0]  op;
    logic [5:0]  op3;
    logic        wt;
    logic [10:0] cs_addr;
    logic [10:0] micro_pc;
    logic        decode;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_upc      = 0;
    bit m_prime    = 1'b1;
    bit m_pc_known = 1'b0;

    cs_address_sequencer dut (
        .CS_ADDRESS_SEQUENCER_CLOCK_50       (clk),
        .CS_ADDRESS_SEQUENCER_ResetInHigh_In (rst),
        .CS_ADDRESS_SEQUENCER_Tipo_InBus     (tipo),
        .CS_ADDRESS_SEQUENCER_JumpAddr_InBus (jump),
        .CS_ADDRESS_SEQUENCER_IrOp_InBus     (op),
        .CS_ADDRESS_SEQUENCER_IrOp3_InBus    (op3),
        .CS_ADDRESS_SEQUENCER_Wait_In        (wt),
        .CS_ADDRESS_SEQUENCER_CsAddr_OutBus  (cs_addr),
        .CS_ADDRESS_SEQUENCER_MicroPc_OutBus (micro_pc),
        .CS_ADDRESS_SEQUENCER_Decode_Out     (decode),
        .CS_ADDRESS_SEQUENCER_IllegalTipo_Out(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at negedge, check settled outputs, then advance the model on posedge.
    // want_cs / want_pc >= 0 add hand-computed checks on top of the model.
    task automatic step(input logic r, input logic [1:0] t, input logic [10:0] j,
                        input logic [1:0] o, input logic [5:0] o3, input logic w,
                        input string tag, input int want_cs, input int want_pc);
        int exp_cs;
        int exp_dec;
        int exp_ill;
        @(negedge clk);
        rst = r; tipo = t; jump = j; op = o; op3 = o3; wt = w;
        #1;
        exp_cs = 0; exp_dec = 0; exp_ill = 0;
        if (r || m_prime) begin
            exp_cs = 0;
        end else if (w) begin
            exp_cs = m_upc;
        end else begin
            case (t)
                2'd1: exp_cs = int'(j);
                2'd2: begin
                    exp_cs  = 1024 + int'(o) * 256 + int'(o3) * 4;
                    exp_dec = 1;
                end
                default: begin
                    exp_cs  = (m_upc + 1) % 2048;
                    exp_ill = (t == 2'd3) ? 1 : 0;
                end
            endcase
        end
        chk({tag, ".cs_addr"}, 32'(cs_addr), 32'(exp_cs));
        chk({tag, ".decode"},  32'(decode),  32'(exp_dec));
        chk({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
        if (m_pc_known) chk({tag, ".micro_pc"}, 32'(micro_pc), 32'(m_upc));
        if (want_cs >= 0) chk({tag, ".cs_const"}, 32'(cs_addr), 32'(want_cs));
        if (want_pc >= 0) chk({tag, ".pc_const"}, 32'(micro_pc), 32'(want_pc));
        @(posedge clk);
        if (r) begin
            m_upc      = 0;
            m_prime    = 1'b1;
            m_pc_known = 1'b1;
        end else begin
            m_upc   = exp_cs;
            m_prime = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; tipo = 2'd0; jump = '0; op = '0; op3 = '0; wt = 1'b0;

        // Reset for 3 cycles with a pending jump, then PRIME, then the jump lands.
        step(1, 2'd1, 11'h123, 2'd0, 6'd0, 0, "rst0", 0, -1);
        step(1, 2'd1, 11'h123, 2'd0, 6'd0, 0, "rst1", 0, -1);
        step(1, 2'd1, 11'h123, 2'd0, 6'd0, 0, "rst2", 0, 0);
        step(0, 2'd1, 11'h123, 2'd0, 6'd0, 1, "prime", 0, 0);
        step(0, 2'd1, 11'h123, 2'd0, 6'd0, 0, "jump123", 11'h123, 0);
        step(0, 2'd0, 11'h000, 2'd0, 6'd0, 0, "next124", 11'h124, 11'h123);

        // Increment wraps from the top of the store.
        step(0, 2'd1, 11'h7FF, 2'd0, 6'd0, 0, "jump7ff", 11'h7FF, -1);
        step(0, 2'd0, 11'h000, 2'd0, 6'd0, 0, "wrap", 0, 11'h7FF);
        step(0, 2'd0, 11'h000, 2'd0, 6'd0, 0, "after_wrap", 1, 0);

        // Decode dispatch, asserted for exactly one cycle.
        step(0, 2'd2, 11'h000, 2'b10, 6'b111000, 0, "decode", 11'h6E0, -1);
        step(0, 2'd0, 11'h000, 2'b10, 6'b111000, 0, "post_decode", 11'h6E1, 11'h6E0);

        // Wait stalls: address re-presented, jump ignored, then resume with increment.
        step(0, 2'd1, 11'h040, 2'd0, 6'd0, 0, "jump040", 11'h040, -1);
        step(0, 2'd1, 11'h555, 2'd0, 6'd0, 1, "wait0", 11'h040, 11'h040);
        step(0, 2'd1, 11'h555, 2'd0, 6'd0, 1, "wait1", 11'h040, 11'h040);
        step(0, 2'd1, 11'h555, 2'd0, 6'd0, 1, "wait2", 11'h040, 11'h040);
        step(0, 2'd0, 11'h555, 2'd0, 6'd0, 0, "resume", 11'h041, 11'h040);

        // Reserved branch type behaves as next and flags itself.
        step(0, 2'd1, 11'h010, 2'd0, 6'd0, 0, "jump010", 11'h010, -1);
        step(0, 2'd3, 11'h000, 2'd0, 6'd0, 0, "rsvd", 11'h011, 11'h010);
        step(0, 2'd0, 11'h000, 2'd0, 6'd0, 0, "post_rsvd", 11'h012, 11'h011);

        // Reset during HOLD returns to PRIME with uPC cleared.
        step(0, 2'd1, 11'h2AA, 2'd0, 6'd0, 1, "hold0", 11'h012, -1);
        step(0, 2'd1, 11'h2AA, 2'd0, 6'd0, 1, "hold1", 11'h012, 11'h012);
        step(1, 2'd1, 11'h2AA, 2'd0, 6'd0, 1, "rst_hold", 0, 11'h012);
        step(0, 2'd1, 11'h2AA, 2'd0, 6'd0, 1, "prime2", 0, 0);
        step(0, 2'd1, 11'h2AA, 2'd0, 6'd0, 0, "run2", 11'h2AA, 0);

        // Random traffic with occasional resets and frequent stalls.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 2'($urandom_range(0, 3)),
                 11'($urandom_range(0, 2047)),
                 2'($urandom_range(0, 3)),
                 6'($urandom_range(0, 63)),
                 ($urandom_range(0, 3) == 0),
                 "rand", -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
